// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : counter_pkg
//  Purpose : Shared constants, frame state encoding and the state-sequencing
//            helper for the count UART transmitter.
//  Rev     : 1.0  initial release
// ============================================================================
package counter_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         FRAME_BYTES   = 7;
  localparam int         BITS_PER_BYTE = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_CHAN = 3'd2,
    ST_CNT3 = 3'd3,
    ST_CNT2 = 3'd4,
    ST_CNT1 = 3'd5,
    ST_CNT0 = 3'd6,
    ST_CSUM = 3'd7
  } frame_state_t;

  // Byte that follows s in the frame; CSUM wraps back to IDLE.
  function automatic frame_state_t next_frame_state(input frame_state_t s);
    case (s)
      ST_SYNC: return ST_CHAN;
      ST_CHAN: return ST_CNT3;
      ST_CNT3: return ST_CNT2;
      ST_CNT2: return ST_CNT1;
      ST_CNT1: return ST_CNT0;
      ST_CNT0: return ST_CSUM;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module  : uart_byte_tx
//  Purpose : 8N1 byte serialiser paced by a single-cycle baud tick. A byte
//            loaded while idle waits for the next tick to start; a byte loaded
//            in the byte_done cycle starts on that same tick, so consecutive
//            bytes run back to back with no idle bit time between them.
//  Rev     : 1.0  initial release
// ============================================================================
module uart_byte_tx
  import counter_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       byte_done
);

  localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE - 1);

  logic       r_active;   // a bit of this byte is on the line
  logic       r_pend;     // byte loaded, waiting for the tick that starts it
  logic [3:0] r_bit;      // 0 = start, 1..8 = data, 9 = stop
  logic [7:0] r_shift;    // remaining data bits, LSB next; refills with stop level
  logic       r_tx;
  logic       w_byte_done;

  // The tick that ends the stop bit is the byte completion point.
  assign w_byte_done = r_active && baud_tick && (r_bit == LAST_BIT);
  assign byte_done   = w_byte_done;
  assign ready       = (!r_active && !r_pend) || w_byte_done;
  assign tx          = r_tx;

  // Bit sequencing: every line change happens in the cycle after a tick.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_active <= 1'b0;
      r_pend   <= 1'b0;
      r_bit    <= 4'd0;
      r_shift  <= 8'h00;
      r_tx     <= 1'b1;
    end else if (w_byte_done) begin
      if (load) begin
        r_shift <= data;
        r_bit   <= 4'd0;
        r_tx    <= 1'b0;
      end else begin
        r_active <= 1'b0;
      end
    end else if (r_active) begin
      if (baud_tick) begin
        r_bit   <= r_bit + 4'd1;
        r_tx    <= r_shift[0];
        r_shift <= {1'b1, r_shift[7:1]};
      end
    end else if (r_pend) begin
      if (baud_tick) begin
        r_pend   <= 1'b0;
        r_active <= 1'b1;
        r_bit    <= 4'd0;
        r_tx     <= 1'b0;
      end
    end else if (load) begin
      r_shift <= data;
      r_pend  <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/count_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module  : count_uart_tx
//  Purpose : Frames a latched window count as SYNC, channel, four count bytes
//            (MSB first) and an XOR checksum, and sends it at the baud-tick
//            rate through uart_byte_tx.
//  Rev     : 1.0  initial release
// ============================================================================
module count_uart_tx
  import counter_pkg::*;
#(
  parameter int         CNT_W = 32,
  parameter int         CH_W  = 4,
  parameter logic [7:0] SYNC  = SYNC_BYTE
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             baud_tick,
  input  logic             count_valid,
  input  logic [CNT_W-1:0] count_value,
  input  logic [CH_W-1:0]  chan_idx,
  output logic             tx,
  output logic             busy,
  output logic             overrun,
  output logic             frame_done
);

  // The frame carries exactly four count bytes and a one-byte channel field.
  generate
    if (CNT_W != 8 * (FRAME_BYTES - 3) || CH_W > 8) begin : g_bad_params
      $error("count_uart_tx: CNT_W must be 32 and CH_W at most 8");
    end
  endgenerate

  frame_state_t     r_state;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_chan;
  logic [7:0]       r_csum;
  logic             r_busy;
  logic             r_overrun;
  logic             r_frame_done;

  logic [7:0] w_chan_in;
  logic [7:0] w_csum_in;
  logic [7:0] w_byte;
  logic       w_load;
  logic       w_ser_ready;
  logic       w_byte_done;

  assign w_chan_in = 8'(chan_idx);
  assign w_csum_in = w_chan_in ^ count_value[31:24] ^ count_value[23:16]
                   ^ count_value[15:8] ^ count_value[7:0];

  // SYNC is handed over at the latch so its start bit goes out on the first
  // later tick; every other byte is handed over on the previous byte's done.
  assign w_load = w_ser_ready &&
                  ((r_state == ST_IDLE && count_valid) ||
                   (w_byte_done && r_state != ST_IDLE && r_state != ST_CSUM));

  // Byte to load next, selected by the byte currently on the line.
  always_comb begin
    w_byte = SYNC;
    case (r_state)
      ST_SYNC: w_byte = r_chan;
      ST_CHAN: w_byte = r_count[31:24];
      ST_CNT3: w_byte = r_count[23:16];
      ST_CNT2: w_byte = r_count[15:8];
      ST_CNT1: w_byte = r_count[7:0];
      ST_CNT0: w_byte = r_csum;
      default: w_byte = SYNC;
    endcase
  end

  // Frame sequencing, sample latch and the registered status pulses.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_chan       <= 8'h00;
      r_csum       <= 8'h00;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_overrun    <= count_valid && (r_state != ST_IDLE);
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (count_valid) begin
            r_count <= count_value;
            r_chan  <= w_chan_in;
            r_csum  <= w_csum_in;
            r_busy  <= 1'b1;
            r_state <= ST_SYNC;
          end
        end
        ST_CSUM: begin
          if (w_byte_done) begin
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          if (w_byte_done) r_state <= next_frame_state(r_state);
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign overrun    = r_overrun;
  assign frame_done = r_frame_done;

  uart_byte_tx u_byte_tx (
    .clk_in    (clk_in),
    .reset     (reset),
    .baud_tick (baud_tick),
    .load      (w_load),
    .data      (w_byte),
    .tx        (tx),
    .ready     (w_ser_ready),
    .byte_done (w_byte_done)
  );

endmodule
`default_nettype wire
